// File: rtl/data_mem_arbiter.sv
// Core/aux arbiter for the data port of data_mem: request checking, starvation bound,
// one-cycle registered responses. Optional burst lock enabled by defining MEM_ARB_LOCK_EN.
package mem_pkg;
  typedef enum logic [2:0] {
    NO_LOAD, LOAD_BYTE, LOAD_HALF, LOAD_WORD, LOAD_DWORD
  } mem_load_type_t;
  typedef enum logic [2:0] {
    NO_STORE, STORE_BYTE, STORE_HALF, STORE_WORD, STORE_DWORD
  } mem_store_type_t;
endpackage

module data_mem_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 4,
  parameter logic [63:0] DATA_LEN = 64'h20000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            core_valid,
  output logic            core_ready,
  input  logic [63:0]     core_addr,
  input  logic [63:0]     core_wdata,
  input  mem_load_type_t  core_load_type,
  input  mem_store_type_t core_store_type,
  input  logic            core_signed,
  output logic            core_rsp_valid,
  output logic [63:0]     core_rsp_data,
  output logic            core_rsp_err,
  input  logic            aux_valid,
  output logic            aux_ready,
  input  logic [63:0]     aux_addr,
  input  logic [63:0]     aux_wdata,
  input  mem_load_type_t  aux_load_type,
  input  mem_store_type_t aux_store_type,
  input  logic            aux_signed,
  input  logic            aux_lock,
  output logic            aux_rsp_valid,
  output logic [63:0]     aux_rsp_data,
  output logic            aux_rsp_err,
  output logic [63:0]     mem_addr,
  output logic [63:0]     mem_data_in,
  output mem_load_type_t  mem_load_type,
  output mem_store_type_t mem_store_type,
  output logic            mem_signed_type,
  input  logic [63:0]     mem_data_out
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             locked_q, locked_d;
  logic             starve, aux_pri;

  // Index 0 is the core requester, index 1 the aux requester.
  logic [1:0]      req_valid, req_acc, req_noop, req_err, req_fwd, req_load, req_sgn;
  logic [63:0]     req_addr  [2];
  logic [63:0]     req_wdata [2];
  mem_load_type_t  req_lt    [2];
  mem_store_type_t req_st    [2];

  assign req_valid    = {aux_valid, core_valid};
  assign req_sgn      = {aux_signed, core_signed};
  assign req_addr[0]  = core_addr;
  assign req_addr[1]  = aux_addr;
  assign req_wdata[0] = core_wdata;
  assign req_wdata[1] = aux_wdata;
  assign req_lt[0]    = core_load_type;
  assign req_lt[1]    = aux_load_type;
  assign req_st[0]    = core_store_type;
  assign req_st[1]    = aux_store_type;

  assign starve     = (wait_cnt_q == CNT_MAX);
  assign aux_pri    = starve | locked_q;
  assign core_ready = !(aux_valid & aux_pri);
  assign aux_ready  = !core_valid | aux_pri;
  assign req_acc    = req_valid & {aux_ready, core_ready};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_req
      logic        is_ld, is_st, mis_ld, mis_st, oor;
      logic        rsp_valid_q, rsp_valid_d;
      logic        rsp_err_q, rsp_err_d;
      logic [63:0] rsp_data_q, rsp_data_d;

      always_comb begin
        is_ld  = (req_lt[gi] != NO_LOAD);
        is_st  = (req_st[gi] != NO_STORE);
        oor    = (req_addr[gi] >= DATA_LEN);
        mis_ld = 1'b0;
        mis_st = 1'b0;
        case (req_lt[gi])
          LOAD_HALF:  mis_ld = req_addr[gi][0];
          LOAD_WORD:  mis_ld = |req_addr[gi][1:0];
          LOAD_DWORD: mis_ld = |req_addr[gi][2:0];
          default:    mis_ld = 1'b0;
        endcase
        case (req_st[gi])
          STORE_HALF:  mis_st = req_addr[gi][0];
          STORE_WORD:  mis_st = |req_addr[gi][1:0];
          STORE_DWORD: mis_st = |req_addr[gi][2:0];
          default:     mis_st = 1'b0;
        endcase
      end

      // A no-op is never an error, whatever its address.
      assign req_noop[gi] = !is_ld & !is_st;
      assign req_err[gi]  = !req_noop[gi] & ((is_ld & is_st) | mis_ld | mis_st | oor);
      assign req_fwd[gi]  = req_acc[gi] & !req_noop[gi] & !req_err[gi];
      assign req_load[gi] = is_ld;

      always_comb begin
        rsp_valid_d = req_acc[gi] & !req_noop[gi];
        rsp_err_d   = req_acc[gi] & req_err[gi];
        rsp_data_d  = (req_fwd[gi] & req_load[gi]) ? mem_data_out : '0;
      end

      always_ff @(posedge clk) begin
        if (!reset) begin
          rsp_valid_q <= 1'b0;
          rsp_err_q   <= 1'b0;
          rsp_data_q  <= '0;
        end else begin
          rsp_valid_q <= rsp_valid_d;
          rsp_err_q   <= rsp_err_d;
          rsp_data_q  <= rsp_data_d;
        end
      end
    end
  endgenerate

  assign core_rsp_valid = g_req[0].rsp_valid_q;
  assign core_rsp_err   = g_req[0].rsp_err_q;
  assign core_rsp_data  = g_req[0].rsp_data_q;
  assign aux_rsp_valid  = g_req[1].rsp_valid_q;
  assign aux_rsp_err    = g_req[1].rsp_err_q;
  assign aux_rsp_data   = g_req[1].rsp_data_q;

  // At most one requester is accepted, so at most one req_fwd bit is set.
  always_comb begin
    mem_addr        = '0;
    mem_data_in     = '0;
    mem_load_type   = NO_LOAD;
    mem_store_type  = NO_STORE;
    mem_signed_type = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (req_fwd[i]) begin
        mem_addr        = req_addr[i];
        mem_data_in     = req_wdata[i];
        mem_load_type   = req_lt[i];
        mem_store_type  = req_st[i];
        mem_signed_type = req_sgn[i];
      end
    end
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (req_acc[1]) begin
      wait_cnt_d = '0;
    end else if (aux_valid && !aux_ready && !starve) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end
  end

`ifdef MEM_ARB_LOCK_EN
  always_comb begin
    locked_d = locked_q;
    if (req_acc[1]) begin
      locked_d = aux_lock;
    end
  end
`else
  logic unused_aux_lock;
  assign unused_aux_lock = aux_lock;
  assign locked_d        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      wait_cnt_q <= '0;
      locked_q   <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      locked_q   <= locked_d;
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter with a behavioural data_mem model;
// exercises the lock path when MEM_ARB_LOCK_EN is defined.
`timescale 1ns/1ps
module tb_data_mem_arbiter;
  import mem_pkg::*;

  localparam int          MAX_WAIT  = 4;
  localparam logic [63:0] DATA_LEN  = 64'h20000;
  localparam int          MEM_BYTES = 'h20000;

  typedef struct {
    logic            v;
    logic [63:0]     addr;
    logic [63:0]     wdata;
    mem_load_type_t  lt;
    mem_store_type_t st;
    logic            sgn;
  } req_t;

  typedef struct {
    logic [63:0] data;
    logic        err;
  } rsp_t;

  logic clk, reset;
  logic core_valid, core_ready, core_signed, core_rsp_valid, core_rsp_err;
  logic [63:0] core_addr, core_wdata, core_rsp_data;
  mem_load_type_t core_load_type;
  mem_store_type_t core_store_type;
  logic aux_valid, aux_ready, aux_signed, aux_lock, aux_rsp_valid, aux_rsp_err;
  logic [63:0] aux_addr, aux_wdata, aux_rsp_data;
  mem_load_type_t aux_load_type;
  mem_store_type_t aux_store_type;
  logic [63:0] mem_addr, mem_data_in, mem_data_out;
  mem_load_type_t mem_load_type;
  mem_store_type_t mem_store_type;
  logic mem_signed_type;

  bit [7:0] env_mem [MEM_BYTES];
  bit [7:0] ref_mem [MEM_BYTES];
  rsp_t core_q[$];
  rsp_t aux_q[$];
  int  m_wait;
  bit  m_locked;
  int  n_checks, n_errors, cyc;

  data_mem_arbiter #(.MAX_WAIT(MAX_WAIT), .DATA_LEN(DATA_LEN)) dut (
    .clk(clk), .reset(reset),
    .core_valid(core_valid), .core_ready(core_ready), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_load_type(core_load_type),
    .core_store_type(core_store_type), .core_signed(core_signed),
    .core_rsp_valid(core_rsp_valid), .core_rsp_data(core_rsp_data), .core_rsp_err(core_rsp_err),
    .aux_valid(aux_valid), .aux_ready(aux_ready), .aux_addr(aux_addr),
    .aux_wdata(aux_wdata), .aux_load_type(aux_load_type),
    .aux_store_type(aux_store_type), .aux_signed(aux_signed), .aux_lock(aux_lock),
    .aux_rsp_valid(aux_rsp_valid), .aux_rsp_data(aux_rsp_data), .aux_rsp_err(aux_rsp_err),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_load_type(mem_load_type),
    .mem_store_type(mem_store_type), .mem_signed_type(mem_signed_type),
    .mem_data_out(mem_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int ld_size(input mem_load_type_t lt);
    case (lt)
      LOAD_BYTE: return 1;
      LOAD_HALF: return 2;
      LOAD_WORD: return 4;
      LOAD_DWORD: return 8;
      default: return 0;
    endcase
  endfunction

  function automatic int st_size(input mem_store_type_t st);
    case (st)
      STORE_BYTE: return 1;
      STORE_HALF: return 2;
      STORE_WORD: return 4;
      STORE_DWORD: return 8;
      default: return 0;
    endcase
  endfunction

  function automatic logic [63:0] load_bytes(input bit use_ref, input logic [63:0] addr,
                                             input mem_load_type_t lt, input logic sgn);
    logic [63:0] v = '0;
    int n = ld_size(lt);
    for (int k = 0; k < n; k++) begin
      if (addr + 64'(k) < 64'(MEM_BYTES))
        v[8*k +: 8] = use_ref ? ref_mem[addr + 64'(k)] : env_mem[addr + 64'(k)];
    end
    if (sgn && n > 0 && n < 8 && v[8*n-1]) v = v | ~((64'd1 << (8*n)) - 64'd1);
    return v;
  endfunction

  task automatic store_bytes(input bit use_ref, input logic [63:0] addr,
                             input mem_store_type_t st, input logic [63:0] data);
    for (int k = 0; k < st_size(st); k++) begin
      if (addr + 64'(k) < 64'(MEM_BYTES)) begin
        if (use_ref) ref_mem[addr + 64'(k)] = data[8*k +: 8];
        else         env_mem[addr + 64'(k)] = data[8*k +: 8];
      end
    end
  endtask

  // data_mem commits stores at the negedge of the acceptance cycle.
  always @(negedge clk) begin
    if (mem_store_type != NO_STORE) store_bytes(1'b0, mem_addr, mem_store_type, mem_data_in);
  end

  // 0 = no-op, 1 = error, 2 = forwarded to memory
  function automatic int classify(input req_t r);
    bit ld = (r.lt != NO_LOAD);
    bit st = (r.st != NO_STORE);
    int sz;
    if (!ld && !st) return 0;
    if (ld && st) return 1;
    if (r.addr >= DATA_LEN) return 1;
    sz = ld ? ld_size(r.lt) : st_size(r.st);
    if ((r.addr % 64'(sz)) != 0) return 1;
    return 2;
  endfunction

  function automatic req_t mk(input logic v, input logic [63:0] addr, input logic [63:0] wdata,
                              input mem_load_type_t lt, input mem_store_type_t st, input logic sgn);
    req_t r;
    r.v = v; r.addr = addr; r.wdata = wdata; r.lt = lt; r.st = st; r.sgn = sgn;
    return r;
  endfunction

  task automatic check_rsp(input bit is_aux);
    rsp_t e;
    logic v, er, exp_v;
    logic [63:0] d;
    string nm = is_aux ? "aux" : "core";
    v  = is_aux ? aux_rsp_valid : core_rsp_valid;
    d  = is_aux ? aux_rsp_data : core_rsp_data;
    er = is_aux ? aux_rsp_err : core_rsp_err;
    e.data = '0; e.err = 1'b0; exp_v = 1'b0;
    if (is_aux && aux_q.size() > 0) begin
      e = aux_q.pop_front(); exp_v = 1'b1;
    end else if (!is_aux && core_q.size() > 0) begin
      e = core_q.pop_front(); exp_v = 1'b1;
    end
    check_eq({nm, "_rsp_valid"}, 64'(v), 64'(exp_v));
    check_eq({nm, "_rsp_data"}, d, e.data);
    check_eq({nm, "_rsp_err"}, 64'(er), 64'(e.err));
    if (v) $display("cycle %0d %s rsp data=%h err=%0d", cyc, nm, d, er);
  endtask

  task automatic step(input req_t c, input req_t a, input logic lock, input logic rst_n);
    bit pri, exp_cr, exp_ar, c_acc, a_acc;
    int cls;
    req_t w;
    rsp_t e;
    @(posedge clk);
    #1;
    cyc++;
    check_rsp(1'b0);
    check_rsp(1'b1);
    reset = rst_n; aux_lock = lock;
    core_valid = c.v; core_addr = c.addr; core_wdata = c.wdata;
    core_load_type = c.lt; core_store_type = c.st; core_signed = c.sgn;
    aux_valid = a.v; aux_addr = a.addr; aux_wdata = a.wdata;
    aux_load_type = a.lt; aux_store_type = a.st; aux_signed = a.sgn;
    #1;
    mem_data_out = load_bytes(1'b0, mem_addr, mem_load_type, mem_signed_type);
    #1;
    if (!rst_n) begin
      m_wait = 0;
      m_locked = 1'b0;
    end else begin
      pri    = (m_wait == MAX_WAIT) || m_locked;
      exp_cr = !(a.v && pri);
      exp_ar = !c.v || pri;
      c_acc  = c.v && exp_cr;
      a_acc  = a.v && exp_ar;
      check_eq("core_ready", 64'(core_ready), 64'(exp_cr));
      check_eq("aux_ready", 64'(aux_ready), 64'(exp_ar));
      if (a_acc) w = a; else w = c;
      cls = (c_acc || a_acc) ? classify(w) : 0;
      if (cls == 2) begin
        check_eq("mem_addr", mem_addr, w.addr);
        check_eq("mem_data_in", mem_data_in, w.wdata);
        check_eq("mem_load_type", 64'(mem_load_type), 64'(w.lt));
        check_eq("mem_store_type", 64'(mem_store_type), 64'(w.st));
        check_eq("mem_signed", 64'(mem_signed_type), 64'(w.sgn));
      end else begin
        check_eq("mem_addr_idle", mem_addr, 64'd0);
        check_eq("mem_data_in_idle", mem_data_in, 64'd0);
        check_eq("mem_load_idle", 64'(mem_load_type), 64'(NO_LOAD));
        check_eq("mem_store_idle", 64'(mem_store_type), 64'(NO_STORE));
        check_eq("mem_signed_idle", 64'(mem_signed_type), 64'd0);
      end
      if (cls != 0) begin
        e.err  = (cls == 1);
        e.data = (cls == 2 && w.lt != NO_LOAD) ? load_bytes(1'b1, w.addr, w.lt, w.sgn) : 64'd0;
        if (cls == 2 && w.st != NO_STORE) store_bytes(1'b1, w.addr, w.st, w.wdata);
        if (a_acc) aux_q.push_back(e); else core_q.push_back(e);
      end
      if (a_acc) m_wait = 0;
      else if (a.v && !exp_ar && m_wait < MAX_WAIT) m_wait++;
`ifdef MEM_ARB_LOCK_EN
      if (a_acc) m_locked = lock;
`endif
    end
  endtask

  initial begin
    req_t idle, rc, ra;
    int sel;
    n_checks = 0; n_errors = 0; cyc = 0; m_wait = 0; m_locked = 1'b0;
    idle = mk(1'b0, 64'd0, 64'd0, NO_LOAD, NO_STORE, 1'b0);
    reset = 1'b0; aux_lock = 1'b0; mem_data_out = '0;
    core_valid = 1'b0; core_addr = '0; core_wdata = '0; core_load_type = NO_LOAD;
    core_store_type = NO_STORE; core_signed = 1'b0;
    aux_valid = 1'b0; aux_addr = '0; aux_wdata = '0; aux_load_type = NO_LOAD;
    aux_store_type = NO_STORE; aux_signed = 1'b0;

    step(idle, idle, 1'b0, 1'b0);
    step(idle, idle, 1'b0, 1'b0);

    // Store then signed load, cross-requester reads, back-to-back store-to-load.
    step(mk(1, 64'h100, 64'hDEADBEEF, NO_LOAD, STORE_WORD, 0), idle, 0, 1);
    step(mk(1, 64'h100, 64'd0, LOAD_WORD, NO_STORE, 1), idle, 0, 1);
    step(idle, mk(1, 64'h102, 64'd0, LOAD_HALF, NO_STORE, 1), 0, 1);
    step(idle, mk(1, 64'h200, 64'h0123456789ABCDEF, NO_LOAD, STORE_DWORD, 0), 0, 1);
    step(mk(1, 64'h207, 64'd0, LOAD_BYTE, NO_STORE, 0), idle, 0, 1);

    // Continuous contention: aux must win once the counter saturates.
    for (int i = 0; i < 10; i++)
      step(mk(1, 64'h100, 64'd0, LOAD_WORD, NO_STORE, 0),
           mk(1, 64'h200, 64'd0, LOAD_DWORD, NO_STORE, 0), 0, 1);

    // Misaligned, out-of-range, malformed and no-op requests.
    step(mk(1, 64'h104, 64'd0, LOAD_DWORD, NO_STORE, 0),
         mk(1, DATA_LEN, 64'h55, NO_LOAD, STORE_HALF, 0), 0, 1);
    step(idle, mk(1, DATA_LEN, 64'h55, NO_LOAD, STORE_HALF, 0), 0, 1);
    step(mk(1, 64'h40, 64'h1, LOAD_BYTE, STORE_BYTE, 0), idle, 0, 1);
    step(mk(1, 64'h40, 64'h1, NO_LOAD, NO_STORE, 0), mk(1, DATA_LEN, 64'd0, NO_LOAD, NO_STORE, 0), 0, 1);
    step(idle, mk(1, DATA_LEN + 64'd8, 64'd0, NO_LOAD, NO_STORE, 0), 0, 1);
    step(idle, idle, 0, 1);

    // Burst lock sequence (lock is ignored when the feature is compiled out).
    step(idle, mk(1, 64'h300, 64'h11, NO_LOAD, STORE_BYTE, 0), 1, 1);
    for (int i = 0; i < 3; i++)
      step(mk(1, 64'h100, 64'd0, LOAD_WORD, NO_STORE, 0),
           mk(1, 64'h301 + 64'(i), 64'(i + 2), NO_LOAD, STORE_BYTE, 0), 1, 1);
    step(mk(1, 64'h100, 64'd0, LOAD_WORD, NO_STORE, 0),
         mk(1, 64'h300, 64'd0, LOAD_WORD, NO_STORE, 0), 0, 1);
    step(mk(1, 64'h300, 64'd0, LOAD_WORD, NO_STORE, 0),
         mk(1, 64'h300, 64'd0, LOAD_BYTE, NO_STORE, 0), 0, 1);
    for (int i = 0; i < 6; i++) step(idle, mk(1, 64'h300, 64'd0, LOAD_BYTE, NO_STORE, 0), 0, 1);

    // Reset after a load acceptance, with the counter part-way up.
    step(mk(1, 64'h100, 64'd0, LOAD_WORD, NO_STORE, 0), mk(1, 64'h200, 64'd0, LOAD_BYTE, NO_STORE, 0), 0, 1);
    step(mk(1, 64'h100, 64'd0, LOAD_WORD, NO_STORE, 0), mk(1, 64'h200, 64'd0, LOAD_BYTE, NO_STORE, 0), 0, 1);
    step(mk(1, 64'h100, 64'd0, LOAD_WORD, NO_STORE, 1), idle, 0, 1);
    step(mk(1, 64'h100, 64'd0, LOAD_WORD, NO_STORE, 0), mk(1, 64'h200, 64'd0, LOAD_BYTE, NO_STORE, 0), 0, 0);
    for (int i = 0; i < 6; i++)
      step(mk(1, 64'h100, 64'd0, LOAD_HALF, NO_STORE, 1), mk(1, 64'h204, 64'd0, LOAD_WORD, NO_STORE, 0), 0, 1);

    // Random mixed traffic.
    for (int i = 0; i < 150; i++) begin
      for (int r = 0; r < 2; r++) begin
        req_t q;
        q.v = ($urandom_range(0, 3) != 0);
        q.addr = 64'($urandom_range(0, 1023));
        if ($urandom_range(0, 1) != 0) q.addr = q.addr & ~64'h7;
        if ($urandom_range(0, 19) == 0) q.addr = DATA_LEN - 64'd16 + 64'($urandom_range(0, 31));
        q.wdata = {$urandom(), $urandom()};
        q.sgn = 1'($urandom_range(0, 1));
        q.lt = NO_LOAD; q.st = NO_STORE;
        sel = $urandom_range(0, 9);
        if (sel == 1 || (sel >= 2 && sel <= 5)) q.lt = mem_load_type_t'($urandom_range(1, 4));
        if (sel == 1 || sel >= 6) q.st = mem_store_type_t'($urandom_range(1, 4));
        if (r == 0) rc = q; else ra = q;
      end
      step(rc, ra, ($urandom_range(0, 4) == 0), 1);
    end

    step(idle, idle, 0, 1);
    step(idle, idle, 0, 1);
    check_eq("core_q_drained", 64'(core_q.size()), 64'd0);
    check_eq("aux_q_drained", 64'(aux_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Single-cycle arbiter sharing the data-side port of the unified `data_mem` between two requesters: the core load/store stage (`core_*`) and an auxiliary master (`aux_*`, debug loader / DMA). Core has fixed priority, bounded by a starvation counter that forces an aux grant after `MAX_WAIT` lost cycles. Requests are checked for alignment and range before they reach memory. Each accepted request returns one registered response one cycle later. Instruction fetch stays on `data_mem`'s separate `inst` port and is not arbitrated.

## Interface
- `MAX_WAIT`, 4: consecutive cycles aux may be denied before it takes priority; ≥1.
- `DATA_LEN`, 'h20000: memory size in bytes; requests with `addr >= DATA_LEN` are errors.
- `clk` in 1: single clock; all state updates on posedge.
- `reset` in 1: synchronous, active-low.
- `core_valid`, `aux_valid` in 1: request valid.
- `core_ready`, `aux_ready` out 1: request accepted when `valid & ready`.
- `core_addr`, `aux_addr` in 64: byte address.
- `core_wdata`, `aux_wdata` in 64: store data, LSB-aligned.
- `core_load_type`, `aux_load_type` in `mem_load_type_t`: requested load size.
- `core_store_type`, `aux_store_type` in `mem_store_type_t`: requested store size.
- `core_signed`, `aux_signed` in 1: load sign extension.
- `aux_lock` in 1: burst lock request; see Configuration.
- `core_rsp_valid`, `aux_rsp_valid` out 1: one-cycle response pulse.
- `core_rsp_data`, `aux_rsp_data` out 64: load data; 0 for stores and errors.
- `core_rsp_err`, `aux_rsp_err` out 1: misaligned, out of range, or malformed request.
- `mem_addr` out 64, `mem_data_in` out 64, `mem_load_type` out `mem_load_type_t`, `mem_store_type` out `mem_store_type_t`, `mem_signed_type` out 1: drive `data_mem`.
- `mem_data_out` in 64: combinational read data from `data_mem`.

## Operation
- Priority flag: `aux_pri = starve | locked`.
  - `core_ready = !(aux_valid & aux_pri)`.
  - `aux_ready = !core_valid | aux_pri`.
  - Ready never depends on the requester's own valid. At most one request is accepted per cycle.
- Request classes:
  - No-op: `NO_LOAD` and `NO_STORE`. Accepted, no memory op, no response.
  - Malformed: load and store both non-NO. Error response.
  - Misaligned: HALF with `addr[0]`≠0, WORD with `addr[1:0]`≠0, DWORD with `addr[2:0]`≠0. Error response.
  - Out of range: `addr >= DATA_LEN`. Error response.
  - Valid: forwarded to memory.
- Memory drive:
  - Valid accepted request: `mem_*` equal the winner's fields in the acceptance cycle.
  - Otherwise: `mem_load_type=NO_LOAD`, `mem_store_type=NO_STORE`, `mem_addr=0`, `mem_data_in=0`, `mem_signed_type=0`. Error requests never drive memory.
- Response register, loaded at posedge for the winner:
  - `rsp_valid=1`.
  - `rsp_err` per the request class.
  - `rsp_data = mem_data_out` for a valid load, else 0.
  - All response outputs are 0 in cycles with no acceptance.
- Starvation counter `wait_cnt`, width `$clog2(MAX_WAIT+1)`:
  - Increments when `aux_valid & !aux_ready`; saturates at `MAX_WAIT`.
  - Clears when aux is accepted.
  - `starve = (wait_cnt == MAX_WAIT)`.
- Reset (low at posedge): `wait_cnt=0`, `locked=0`, all response outputs 0. A response pending for the reset cycle is dropped.

## Timing
- Acceptance cycle N: `mem_*` are driven combinationally in N. `data_mem` commits stores at the negedge inside N.
- Response: asserted for exactly cycle N+1.
- Store-to-load: a store accepted in N is visible to a load accepted in N+1, including a load from the other requester.
- Back-to-back acceptances are allowed every cycle. The aux requester is granted at most `MAX_WAIT+1` cycles after it first asserts valid under continuous core load.
- Simultaneous valid: core wins unless `aux_pri`. Under `aux_pri` aux wins and `wait_cnt` clears.
- Deasserting `aux_valid` does not clear `wait_cnt`; only aux acceptance or reset clears it.

## Configuration
- `MEM_ARB_LOCK_EN` defined:
  - `locked` is set when aux is accepted with `aux_lock=1`, and cleared when aux is accepted with `aux_lock=0`.
  - While locked, aux has priority every cycle and core waits.
  - Reset clears `locked`.
- `MEM_ARB_LOCK_EN` undefined: `aux_lock` is ignored and `locked` is constant 0.

## Test plan
- Core WORD store `addr=0x100`, `wdata=0xDEADBEEF`, then core WORD load with `signed=1` at 0x100 → load response in the following cycle `rsp_data=0xFFFFFFFFDEADBEEF`, `rsp_err=0`.
- Core and aux both valid for 10 cycles, `MAX_WAIT=4` → core accepted cycles 0–3, aux accepted cycle 4, `wait_cnt` back to 0, core resumes cycle 5.
- Core DWORD load at 0x104 and aux HALF store at `DATA_LEN` → each gets `rsp_err=1`, `rsp_data=0`; `mem_store_type` stays `NO_STORE` throughout.
- Request with `LOAD_BYTE` and `STORE_BYTE` together → error response. Request with `NO_LOAD`/`NO_STORE` → accepted, no response.
- With `MEM_ARB_LOCK_EN`: aux accepted with `aux_lock=1`, then 3 aux requests with core valid → core_ready low until aux accepted with `aux_lock=0`, then core wins next cycle.
- `reset` low in the cycle after a load acceptance → no `rsp_valid` after reset; counter 0; next core request accepted normally.
